// File: rtl/tmr_scrub_pkg.sv
// Shared encodings for the triple-redundant scrubbed register.
// Mode and injection-lane values are common to the RTL and its regression bench.
package tmr_scrub_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_INV  = 2'b11
    } mode_t;

    localparam logic [1:0] LANE_NONE = 2'd3;

endpackage

// File: rtl/tmr_majority_voter.sv
// Bitwise 2-of-3 majority vote over three register copies.
// Mismatch reports any copy that disagrees with the voted value.
module tmr_majority_voter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] vote,
    output logic             mismatch
);

    assign vote     = (a & b) | (a & c) | (b & c);
    assign mismatch = (|(a ^ vote)) | (|(b ^ vote)) | (|(c ^ vote));

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triple-redundant data register: majority vote, per-edge scrub of all copies,
// fault injection into one copy, registered mismatch flag and saturating counter.
module tmr_scrub_reg
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAP   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             inj_en,
    input  logic [1:0]       inj_lane,
    input  logic [WIDTH-1:0] inj_mask,
    input  logic             clr_count,
    output logic [WIDTH-1:0] out_data,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] r0, r1, r2;
    logic [WIDTH-1:0] vote;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] m0, m1, m2;
    logic             mismatch;

    tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
        .a        (r0),
        .b        (r1),
        .c        (r2),
        .vote     (vote),
        .mismatch (mismatch)
    );

    assign out_data = vote;

    // The update is derived from the voted value only, so a corrupted copy
    // can never leak into the next state.
    always_comb begin
        // NOTE: default first so every path assigns next_val and no latch is inferred.
        next_val = vote;
        if (in_valid) begin
            case (mode_t'(mode))
                MODE_LOAD: next_val = in_data;
                MODE_XOR:  next_val = in_data ^ vote;
                MODE_INV:  next_val = in_data ^ {WIDTH{~in_data[TAP]}};
                default:   next_val = vote;
            endcase
        end
    end

    always_comb begin
        m0 = '0;
        m1 = '0;
        m2 = '0;
        if (inj_en) begin
            case (inj_lane)
                2'd0:    m0 = inj_mask;
                2'd1:    m1 = inj_mask;
                2'd2:    m2 = inj_mask;
                default: ;  // LANE_NONE: no corruption
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all copies sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            r0 <= next_val ^ m0;
            r1 <= next_val ^ m1;
            r2 <= next_val ^ m2;
        end
    end

    // Clear has priority over a coincident mismatch; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            err_flag <= mismatch;
            if (clr_count)
                err_count <= '0;
            else if (mismatch && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Directed bench for tmr_scrub_reg: update modes, single-lane injection and scrub,
// counter saturation (narrow instance), clear priority and asynchronous reset.
module tb_tmr_scrub_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] mode;
    logic [7:0] in_data;
    logic       inj_en;
    logic [1:0] inj_lane;
    logic [7:0] inj_mask;
    logic       clr_count;

    logic [7:0]  out_data,  s_out_data;
    logic        err_flag,  s_err_flag;
    logic [15:0] err_count;
    logic [1:0]  s_err_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tmr_scrub_reg #(.WIDTH(8), .TAP(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .in_data(in_data),
        .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask), .clr_count(clr_count),
        .out_data(out_data), .err_flag(err_flag), .err_count(err_count)
    );

    tmr_scrub_reg #(.WIDTH(8), .TAP(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .in_data(in_data),
        .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask), .clr_count(clr_count),
        .out_data(s_out_data), .err_flag(s_err_flag), .err_count(s_err_count)
    );

    // Advance one active edge and settle past it before checking or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inject_off();
        inj_en   = 1'b0;
        inj_lane = 2'd3;
        inj_mask = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; mode = 2'b00; in_data = 8'h00; clr_count = 1'b0;
        inject_off();
        step();
        step();
        vectors++;
        if (out_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_out_data got=%h exp=00", out_data);
        end
        vectors++;
        if (err_flag !== 1'b0) begin
            miscompares++; $display("FAIL reset_err_flag got=%b exp=0", err_flag);
        end
        vectors++;
        if (err_count !== 16'd0) begin
            miscompares++; $display("FAIL reset_err_count got=%0d exp=0", err_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_modes();
        logic [7:0] exp_data [6];
        logic [1:0] mode_v   [6];
        logic [7:0] data_v   [6];
        logic       valid_v  [6];
        // load A5, xor 0F -> AA, inv-tap 00 -> FF, inv-tap 04 -> 04, invalid load -> hold, hold mode
        valid_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        mode_v   = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
        data_v   = '{8'hA5, 8'h0F, 8'h00, 8'h04, 8'h55, 8'h33};
        exp_data = '{8'hA5, 8'hAA, 8'hFF, 8'h04, 8'h04, 8'h04};
        for (int i = 0; i < 6; i++) begin
            in_valid = valid_v[i]; mode = mode_v[i]; in_data = data_v[i];
            step();
            vectors++;
            if (out_data !== exp_data[i]) begin
                miscompares++;
                $display("FAIL mode_vec%0d got=%h exp=%h", i, out_data, exp_data[i]);
            end
        end
        vectors++;
        if (err_flag !== 1'b0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL modes_no_error flag=%b count=%0d exp flag=0 count=0", err_flag, err_count);
        end
        in_valid = 1'b1; mode = 2'b01; in_data = 8'hA5;
        step();
        in_valid = 1'b0; mode = 2'b00;
    endtask

    task automatic test_single_inject();
        logic [7:0]  exp_out  [3];
        logic        exp_flag [3];
        logic [15:0] exp_cnt  [3];
        exp_out  = '{8'hA5, 8'hA5, 8'hA5};
        exp_flag = '{1'b0, 1'b1, 1'b0};
        exp_cnt  = '{16'd0, 16'd1, 16'd1};
        inj_en = 1'b1; inj_lane = 2'd1; inj_mask = 8'h81;
        for (int i = 0; i < 3; i++) begin
            step();
            inject_off();
            vectors++;
            if (out_data !== exp_out[i] || err_flag !== exp_flag[i] || err_count !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL single_inject_cyc%0d out=%h flag=%b cnt=%0d exp out=%h flag=%b cnt=%0d",
                         i, out_data, err_flag, err_count, exp_out[i], exp_flag[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  lane_v   [5];
        logic        en_v     [5];
        logic        exp_flag [5];
        logic [15:0] exp_cnt  [5];
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        vectors++;
        if (err_count !== 16'd0) begin
            miscompares++; $display("FAIL clear_idle got=%0d exp=0", err_count);
        end
        // lane 0, lane 2, idle, idle, then lane 3 (no effect)
        en_v     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        lane_v   = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_flag = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_cnt  = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
        for (int i = 0; i < 5; i++) begin
            inj_en = en_v[i]; inj_lane = lane_v[i]; inj_mask = (lane_v[i] == 2'd3) ? 8'hFF : 8'h01;
            step();
            vectors++;
            if (out_data !== 8'hA5 || err_flag !== exp_flag[i] || err_count !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL back_to_back_cyc%0d out=%h flag=%b cnt=%0d exp out=a5 flag=%b cnt=%0d",
                         i, out_data, err_flag, err_count, exp_flag[i], exp_cnt[i]);
            end
        end
        inject_off();
        step();
        vectors++;
        if (err_flag !== 1'b0 || err_count !== 16'd2) begin
            miscompares++;
            $display("FAIL lane_none flag=%b cnt=%0d exp flag=0 cnt=2", err_flag, err_count);
        end
    endtask

    task automatic test_inject_with_update();
        in_valid = 1'b1; mode = 2'b01; in_data = 8'h3C;
        inj_en = 1'b1; inj_lane = 2'd0; inj_mask = 8'hFF;
        step();
        in_valid = 1'b0; mode = 2'b00;
        inject_off();
        vectors++;
        if (out_data !== 8'h3C) begin
            miscompares++; $display("FAIL inject_update_out got=%h exp=3c", out_data);
        end
        step();
        vectors++;
        if (out_data !== 8'h3C || err_flag !== 1'b1 || err_count !== 16'd3) begin
            miscompares++;
            $display("FAIL inject_update_scrub out=%h flag=%b cnt=%0d exp out=3c flag=1 cnt=3",
                     out_data, err_flag, err_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_small [5];
        exp_small = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inj_en = 1'b1; inj_lane = 2'd1; inj_mask = 8'h01;
            step();
            inject_off();
            step();
            step();
            vectors++;
            if (s_err_count !== exp_small[i] || s_out_data !== 8'h3C) begin
                miscompares++;
                $display("FAIL saturate_occ%0d cnt=%0d out=%h exp cnt=%0d out=3c",
                         i, s_err_count, s_out_data, exp_small[i]);
            end
        end
        vectors++;
        if (err_count !== 16'd5) begin
            miscompares++; $display("FAIL wide_count_5 got=%0d exp=5", err_count);
        end
    endtask

    task automatic test_clear_priority();
        inj_en = 1'b1; inj_lane = 2'd1; inj_mask = 8'h10;
        step();
        inject_off();
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        vectors++;
        if (s_err_count !== 2'd0 || err_count !== 16'd0 || err_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_priority small=%0d wide=%0d flag=%b exp small=0 wide=0 flag=1",
                     s_err_count, err_count, err_flag);
        end
        step();
        vectors++;
        if (err_count !== 16'd0 || err_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_after cnt=%0d flag=%b exp cnt=0 flag=0", err_count, err_flag);
        end
    endtask

    task automatic test_reset_midstream();
        inj_en = 1'b1; inj_lane = 2'd2; inj_mask = 8'hFF;
        step();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_data !== 8'h00 || err_flag !== 1'b0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset out=%h flag=%b cnt=%0d exp all zero", out_data, err_flag, err_count);
        end
        step();
        rst = 1'b0;
        inject_off();
        in_valid = 1'b1; mode = 2'b01; in_data = 8'h3C;
        step();
        in_valid = 1'b0; mode = 2'b00;
        vectors++;
        if (out_data !== 8'h3C || err_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_load out=%h flag=%b exp out=3c flag=0", out_data, err_flag);
        end
        step();
        vectors++;
        if (err_flag !== 1'b0 || err_count !== 16'd0 || out_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL post_reset_clean out=%h flag=%b cnt=%0d exp out=3c flag=0 cnt=0",
                     out_data, err_flag, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_single_inject();
        test_back_to_back();
        test_inject_with_update();
        test_saturation();
        test_clear_priority();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/tmr_scrub_reg.md
# tmr_scrub_reg

Parametrised triple-redundant data register with majority voting, per-cycle scrubbing, mismatch detection and a saturating error counter. It generalises the team's single-register update-with-feedback test design: configurable width, four update modes, and a built-in fault-injection port. It sits in the TMR regression suite as a self-checking target for the triplication flow, and in designs as a hardened state register.

## Interface
- WIDTH, 8, data width (≥ 3)
- TAP, 2, bit index of in_data used by the invert-tap mode (0 ≤ TAP < WIDTH)
- CNT_W, 16, error counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  apply mode this cycle; 0 = hold
- mode  in  2  00 hold, 01 load, 10 xor-accumulate, 11 invert-tap
- in_data  in  WIDTH  operand
- inj_en  in  1  fault-injection strobe
- inj_lane  in  2  copy to corrupt: 0, 1 or 2; 3 = none
- inj_mask  in  WIDTH  bits XORed into the selected copy
- clr_count  in  1  synchronous clear of err_count
- out_data  out  WIDTH  voted value
- err_flag  out  1  registered mismatch indication
- err_count  out  CNT_W  saturating mismatch-cycle count

## Operation
- Three copies r0, r1, r2. v = bitwise majority(r0, r1, r2). out_data = v (combinational from the registers).
- next, computed from v, never from an individual copy:
  - in_valid=0, or mode 00: next = v
  - mode 01: next = in_data
  - mode 10: next = in_data ^ v
  - mode 11: next = in_data ^ {WIDTH{~in_data[TAP]}}
- Every edge, all three copies are written with next (scrub). This corrects any single-copy upset on the following edge.
- Injection: if inj_en=1 and inj_lane<3, copy inj_lane is written with next ^ inj_mask and the other two with next. inj_lane=3 has no effect.
- mismatch = (r0≠v) | (r1≠v) | (r2≠v), evaluated on current register contents.
- err_flag <= mismatch.
- err_count:
  - clr_count=1: cleared to 0. Clear wins over a simultaneous mismatch.
  - otherwise: +1 on each mismatch cycle, saturating at 2^CNT_W−1.
- A double fault on the same bit in two copies yields a wrong v. Mismatch is still flagged; no correction is attempted.
- Reset values: r0/r1/r2 = 0, out_data = 0, err_flag = 0, err_count = 0. Reset asserted mid-operation clears everything immediately, including a pending injection.

## Timing
- Update latency is 1 cycle: the value applied at edge N is visible on out_data after edge N.
- An injection at edge N creates a mismatch during cycle N..N+1, which is scrubbed at edge N+1.
  - err_flag is high for exactly the one cycle after edge N+1.
  - err_count is +1 after edge N+1.
- Injection and mode update in the same cycle: the corrupted copy holds next ^ mask. out_data still shows next for a single-lane fault.
- No handshake; in_valid is sampled every edge.

## Structure
- Package tmr_scrub_pkg: mode encodings (MODE_HOLD, MODE_LOAD, MODE_XOR, MODE_INV), LANE_NONE=2'd3.
- Sub-module tmr_majority_voter #(WIDTH): combinational bitwise vote plus mismatch output. One instance.
- Copy registers and the error counter live in the top module.

## Test plan
- Reset, then load 8'hA5 (mode 01) → out_data=A5 after 1 edge; err_flag=0, err_count=0.
- From A5, xor-accumulate 8'h0F → 8'hAA. Then invert-tap with in_data=8'h00 (TAP bit 0 → invert) → 8'hFF.
- Hold A5 and inject lane 1, mask 8'h81 → out_data stays A5 throughout; err_flag pulses exactly once, one cycle after scrub; err_count=1.
- Inject lanes 0 and 2 with mask 8'h01 on consecutive cycles → each corrected; err_count=2; out_data constant.
- With CNT_W=2, inject on 5 separate occasions → err_count saturates at 3. Then clr_count coincident with a mismatch cycle → err_count=0.
- Assert rst mid-stream with a copy corrupted → all outputs 0 immediately. After release, load 8'h3C works and err_flag stays 0.
